// File: rtl/note_mem_arb_pkg.sv
// rtl/note_mem_arb_pkg.sv - shared error-bit indices, counter width and address checks
package note_mem_arb_pkg;

  localparam int ERR_RANGE    = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_CNT_W    = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Any set bit above the implemented byte range makes the access out of range.
  function automatic logic addr_oor(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/note_mem_arb_rr_arbiter.sv
// rtl/note_mem_arb_rr_arbiter.sv - round-robin arbiter with one-hot grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx;
  logic             found;
  int               idx;

  // Search upward from ptr_q with wrap; the first requester wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gidx == PTR_W'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/note_mem_arb.sv
// rtl/note_mem_arb.sv - multi-voice note memory with write priority and error tracking
module note_mem_arb
  import note_mem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int NUM_CH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*32-1:0] req_addr,
  output logic [NUM_CH-1:0]    req_ready,
  output logic [NUM_CH-1:0]    rsp_valid,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [1:0]           rsp_err,
  input  logic                 wr_en,
  input  logic [31:0]          wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic [NUM_CH-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_err_q, rsp_err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [31:0]          rd_addr;
  logic                 rd_go, rd_oor, rd_mis;
  logic                 wr_oor, err_ev;
  logic [DATA_W-1:0]    rd_word;

  // Writes win the cycle outright, and nothing is granted while held in reset.
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (rst_n & ~wr_en),
    .grant (req_ready)
  );

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ready[i]) rd_addr = req_addr[32*i +: 32];
    end
  end

  assign rd_go   = |req_ready;
  assign rd_oor  = rd_go && addr_oor(rd_addr, ADDR_W);
  assign rd_mis  = addr_misaligned(rd_addr);
  assign wr_oor  = wr_en && addr_oor(wr_addr, ADDR_W);
  assign err_ev  = rd_oor | wr_oor;
  assign rd_word = rd_oor ? '0 : mem_q[rd_addr[ADDR_W+1:2]];

  always_ff @(posedge clk) begin
    if (wr_en && !wr_oor) begin
      mem_q[wr_addr[ADDR_W+1:2]] <= wr_data;
    end
  end

  always_comb begin
    rsp_valid_d = req_ready;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (rd_go) begin
      rsp_data_d               = rd_word;
      rsp_err_d[ERR_RANGE]     = rd_oor;
      rsp_err_d[ERR_MISALIGN]  = rd_mis;
    end
  end

  // A clear that coincides with a new error leaves exactly that one error recorded.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (err_clr) begin
      err_sticky_d = err_ev;
      err_cnt_d    = {{(ERR_CNT_W-1){1'b0}}, err_ev};
    end else if (err_ev) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/note_mem_arb.md
NOTE_MEM_ARB -- requirements
Module: note_mem_arb

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 12, word-address width; depth is 2**ADDR_W words, so the implemented byte range is 0 .. 2**(ADDR_W+2)-1.
REQ-003 Parameter NUM_CH, default 4, number of note read channels (voices), range 1..8.
REQ-004 Port list; one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel read request.
- req_addr  in  NUM_CH*32  per-channel byte address; channel i occupies bits [32*i+31:32*i].
- req_ready  out  NUM_CH  per-channel grant; one-hot or zero.
- rsp_valid  out  NUM_CH  per-channel response strobe.
- rsp_data  out  DATA_W  response word, shared by all channels.
- rsp_err  out  2  bit0 = out-of-range, bit1 = misaligned.
- wr_en  in  1  write request.
- wr_addr  in  32  write byte address.
- wr_data  in  DATA_W  write data.
- err_sticky  out  1  latched out-of-range indication.
- err_cnt  out  16  saturating count of out-of-range accesses.
- err_clr  in  1  clears err_sticky and err_cnt.

Function
REQ-005 Memory is a single-port array of 2**ADDR_W words; word index = addr[ADDR_W+1:2]; addr[1:0] is discarded.
REQ-006 An access is out-of-range if any bit addr[31:ADDR_W+2] is 1; it is misaligned if addr[1:0] != 0.
REQ-007 A write occurs on the rising clk edge when wr_en=1 and wr_addr is in range; an out-of-range write is dropped and counted as an error.
REQ-008 Writes have priority: in any cycle with wr_en=1, req_ready is all zero and no read is granted.
REQ-009 Otherwise the round-robin arbiter grants at most one channel: the lowest index i with req_valid[i]=1, searching from pointer ptr upward with wrap-around at NUM_CH-1 -> 0.
REQ-010 On a grant to channel g, ptr becomes (g+1) mod NUM_CH at the clock edge; with no grant, ptr holds.
REQ-011 req_ready is combinational from req_valid, wr_en and ptr; a request completes in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-012 Read latency is exactly 1 cycle: the cycle after a grant, rsp_valid[g]=1 for one cycle, rsp_data = the addressed word, and rsp_err reflects that request's address.
REQ-013 An out-of-range read performs no array access and returns rsp_data=0 with rsp_err[0]=1; a misaligned read returns the truncated word with rsp_err[1]=1.
REQ-014 rsp_data and rsp_err hold their last values while rsp_valid is all zero.
REQ-015 Read-during-write cannot occur, because of REQ-008; a read granted the cycle after a write returns the new data.
REQ-016 Each out-of-range access (read or write) sets err_sticky and increments err_cnt; err_cnt saturates at 16'hFFFF.
REQ-017 err_clr=1 clears err_sticky and err_cnt at the edge; if an error occurs in the same cycle, the result is err_sticky=1 and err_cnt=1.

Reset
REQ-018 While rst_n=0: ptr=0, rsp_valid=0, rsp_data=0, rsp_err=0, err_sticky=0, err_cnt=0, and req_ready=0 regardless of inputs.
REQ-019 Memory contents are not reset.
REQ-020 A reset asserted between grant and response drops that response; no rsp_valid is issued after reset releases.

Structure
REQ-021 A shared package holds the error-bit indices (ERR_RANGE=0, ERR_MISALIGN=1) and the err_cnt width constant (16).
REQ-022 The arbiter is a sub-module rr_arbiter (parameter N, inputs req/en, output one-hot grant, internal ptr).

Verification
REQ-023 After reset release, write 0x12345678 to address 0x10, then channel 0 reads 0x10 -> the next cycle rsp_valid=4'b0001, rsp_data=0x12345678, rsp_err=0.
REQ-024 All four channels hold req_valid for 8 cycles with ptr=0 -> grants occur in order 0,1,2,3,0,1,2,3, one per cycle.
REQ-025 wr_en=1 while channels 1 and 2 request -> req_ready=0 that cycle; the following cycle channel 1 is granted.
REQ-026 Channel 3 reads 0x00004000 (ADDR_W=12) -> rsp_data=0, rsp_err=2'b01, err_sticky=1, err_cnt=1; a read of 0x0000001A returns the word at 0x18 with rsp_err=2'b10.
REQ-027 err_clr asserted in the same cycle as an out-of-range write -> err_cnt=1 and err_sticky=1; err_cnt preloaded to 0xFFFF stays at 0xFFFF on a further error.
REQ-028 rst_n pulsed low on the cycle after a grant -> no rsp_valid is seen, and ptr=0 after release.
